block_mem_responder: RTL and testbench

//  Memory-side responder for the processor's 256-bit block port (io_memAddrs/io_memRead/io_memWrite/
//  io_memWriteBlock/io_memReadBlock). Serves each block request against a 32-bit-wide synchronous word
//  RAM, moving one word per cycle, and signals completion with a one-cycle io_memReady pulse.

---
 rtl/block_mem_responder_if.sv | 31 +++
 rtl/block_mem_responder.sv | 114 +++++++++++
 tb/tb_block_mem_responder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/block_mem_responder_if.sv
// Block-port bundle between the processor, the block responder and the 32-bit word RAM.
// Slave modport is the responder; master is the processor-plus-RAM side.
interface block_mem_responder_if #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 11
);
  localparam int RAM_AW = ADDR_W + $clog2(BLOCK_WORDS);

  logic [ADDR_W-1:0]             io_memAddrs;
  logic                          io_memRead;
  logic                          io_memWrite;
  logic [WORD_W*BLOCK_WORDS-1:0] io_memWriteBlock;
  logic [WORD_W*BLOCK_WORDS-1:0] io_memReadBlock;
  logic                          io_memReady;
  logic                          io_busy;
  logic [RAM_AW-1:0]             ram_addr;
  logic [WORD_W-1:0]             ram_wdata;
  logic                          ram_we;
  logic [WORD_W-1:0]             ram_rdata;

  modport slave (
    input  io_memAddrs, io_memRead, io_memWrite, io_memWriteBlock, ram_rdata,
    output io_memReadBlock, io_memReady, io_busy, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output io_memAddrs, io_memRead, io_memWrite, io_memWriteBlock, ram_rdata,
    input  io_memReadBlock, io_memReady, io_busy, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/block_mem_responder.sv
// Serves 256-bit block reads/writes against a word-wide sync RAM, one word per cycle.
// Write ready 9 cycles after acceptance, read ready 10; requests are held by the requester until io_memReady.
module block_mem_responder #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 11
) (
  input  logic                 clock,
  input  logic                 reset,
  block_mem_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t state, stateNext;

  logic [ADDR_W-1:0]                      addrReg;
  logic [IDX_W-1:0]                       idx;
  logic [IDX_W-1:0]                       idxInc;
  logic [IDX_W-1:0]                       idxPrev;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]     wBlock;
  logic [BLOCK_WORDS-2:0][WORD_W-1:0]     capBuf;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0]     readBlock;
  logic [ADDR_W+IDX_W-1:0]                ramAddr;
  logic [WORD_W-1:0]                      ramWdata;
  logic                                   ramWe;

  assign idxInc  = idx + IDX_W'(1);
  assign idxPrev = idx - IDX_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext       = state;
    bus.io_memReady = 1'b0;
    bus.io_busy     = 1'b1;
    case (state)
      IDLE: begin
        bus.io_busy = 1'b0;
        if (bus.io_memWrite)     stateNext = WRITE;
        else if (bus.io_memRead) stateNext = READ;
      end
      WRITE: if (idx == LAST_IDX) stateNext = DONE;
      READ:  if (idx == LAST_IDX) stateNext = DRAIN;
      DRAIN: stateNext = DONE;
      DONE: begin
        bus.io_memReady = 1'b1;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // RAM-side outputs are registered so they hold their last value between transfers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrReg   <= '0;
      idx       <= '0;
      wBlock    <= '0;
      capBuf    <= '0;
      readBlock <= '0;
      ramAddr   <= '0;
      ramWdata  <= '0;
      ramWe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.io_memWrite || bus.io_memRead) begin
            addrReg <= bus.io_memAddrs;
            idx     <= '0;
            ramAddr <= {bus.io_memAddrs, {IDX_W{1'b0}}};
          end
          if (bus.io_memWrite) begin
            wBlock   <= bus.io_memWriteBlock;
            ramWdata <= bus.io_memWriteBlock[WORD_W-1:0];
            ramWe    <= 1'b1;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            ramWe <= 1'b0;
            idx   <= '0;
          end else begin
            idx      <= idxInc;
            ramAddr  <= {addrReg, idxInc};
            ramWdata <= wBlock[idxInc];
          end
        end
        READ: begin
          // Data for the word issued last cycle is on ram_rdata now.
          if (idx != '0) capBuf[idxPrev] <= bus.ram_rdata;
          if (idx == LAST_IDX) begin
            idx <= '0;
          end else begin
            idx     <= idxInc;
            ramAddr <= {addrReg, idxInc};
          end
        end
        DRAIN: readBlock <= {bus.ram_rdata, capBuf};
        default: ;
      endcase
    end
  end

  assign bus.io_memReadBlock = readBlock;
  assign bus.ram_addr        = ramAddr;
  assign bus.ram_wdata       = ramWdata;
  assign bus.ram_we          = ramWe;
endmodule

// File: tb/tb_block_mem_responder.sv
// Directed + randomized bench for block_mem_responder with a word-RAM model and a block-level reference.
module tb_block_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;

  block_mem_responder_if bus ();

  block_mem_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [31:0]  ram    [0:16383];
  logic [31:0]  refMem [0:16383];
  logic [255:0] expRead;
  int cyc = 0;
  int nTests = 0;
  int nFail = 0;
  int lastReady = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] randBlock();
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after DONE.
  task automatic xfer(input bit wr, input bit rd, input logic [10:0] a, input logic [255:0] blk,
                      input int abortAt, input bit scramble);
    int lat = -1;
    logic [255:0] expBlk;
    logic [2:0] wi;
    for (int w = 0; w < 8; w++) begin
      wi = 3'(w);
      expBlk[32*w +: 32] = refMem[{a, wi}];
    end
    bus.io_memWrite      = wr;
    bus.io_memRead       = rd;
    bus.io_memAddrs      = a;
    bus.io_memWriteBlock = blk;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (scramble && k == 3) begin
        bus.io_memAddrs      = ~a;
        bus.io_memWriteBlock = ~blk;
      end
      if (k == abortAt) begin
        reset = 1'b1;
        #1;
        chk("abortWe", bus.ram_we, 0);
        chk("abortBusy", bus.io_busy, 0);
        chk("abortReady", bus.io_memReady, 0);
        chk("abortReadBlock", bus.io_memReadBlock, 0);
        bus.io_memWrite = 1'b0;
        bus.io_memRead  = 1'b0;
        for (int w = 0; w < k - 1; w++) begin
          wi = 3'(w);
          refMem[{a, wi}] = blk[32*w +: 32];
        end
        expRead = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("abortNoReady", bus.io_memReady, 0);
        end
        return;
      end
      if (k <= 8) begin
        wi = 3'(k - 1);
        chk("busy", bus.io_busy, 1);
        chk("ramWe", bus.ram_we, wr);
        chk("ramAddr", bus.ram_addr, {a, wi});
        if (wr) chk("ramWdata", bus.ram_wdata, blk[32*(k-1) +: 32]);
      end
      if (bus.io_memReady) begin
        lat = k;
        lastReady = cyc;
        bus.io_memWrite = 1'b0;
        bus.io_memRead  = 1'b0;
        break;
      end
    end
    chk("latency", lat, wr ? 9 : 10);
    if (wr) begin
      for (int w = 0; w < 8; w++) begin
        wi = 3'(w);
        refMem[{a, wi}] = blk[32*w +: 32];
      end
    end else begin
      expRead = expBlk;
    end
    chk("readBlock", bus.io_memReadBlock, expRead);
    @(negedge clock);
    chk("readyPulse", bus.io_memReady, 0);
    chk("idleBusy", bus.io_busy, 0);
    chk("idleWe", bus.ram_we, 0);
  endtask

  initial begin
    logic [255:0] blk;
    logic [10:0]  addrTab [4];
    int r1;
    addrTab = '{11'h001, 11'h002, 11'h012, 11'h7FF};
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = '0;
      refMem[i] = '0;
    end
    expRead              = '0;
    bus.io_memRead       = 1'b0;
    bus.io_memWrite      = 1'b0;
    bus.io_memAddrs      = '0;
    bus.io_memWriteBlock = '0;

    // Reset state
    @(negedge clock);
    chk("rstReadBlock", bus.io_memReadBlock, 0);
    chk("rstReady", bus.io_memReady, 0);
    chk("rstBusy", bus.io_busy, 0);
    chk("rstWe", bus.ram_we, 0);
    chk("rstAddr", bus.ram_addr, 0);
    chk("rstWdata", bus.ram_wdata, 0);
    reset = 1'b0;
    @(negedge clock);

    // Known-pattern write then read of block 0x012
    blk = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
           32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    xfer(1'b1, 1'b0, 11'h012, blk, 0, 1'b0);
    xfer(1'b0, 1'b1, 11'h012, '0, 0, 1'b0);
    chk("patternRead", bus.io_memReadBlock, blk);

    // Read and write together at the top block: write wins
    xfer(1'b1, 1'b1, 11'h7FF, randBlock(), 0, 1'b0);
    chk("topWord7", ram[14'h3FFF], refMem[14'h3FFF]);

    // Reset during the fourth write cycle, then read back the partial block
    xfer(1'b1, 1'b0, 11'h012, randBlock(), 4, 1'b0);
    xfer(1'b0, 1'b1, 11'h012, '0, 0, 1'b0);

    // Back-to-back reads
    xfer(1'b1, 1'b0, 11'h001, randBlock(), 0, 1'b0);
    xfer(1'b1, 1'b0, 11'h002, randBlock(), 0, 1'b0);
    xfer(1'b0, 1'b1, 11'h001, '0, 0, 1'b0);
    r1 = lastReady;
    xfer(1'b0, 1'b1, 11'h002, '0, 0, 1'b0);
    chk("backToBackGap", lastReady - r1, 11);

    // Inputs change mid-write; only latched values reach the RAM
    xfer(1'b1, 1'b0, 11'h0A5, randBlock(), 0, 1'b1);
    xfer(1'b0, 1'b1, 11'h0A5, '0, 0, 1'b0);

    // Randomized mix over a small address set so reads hit earlier writes
    for (int n = 0; n < 16; n++) begin
      logic [10:0] a;
      bit wr;
      a  = ($urandom_range(0, 4) == 4) ? 11'($urandom) : addrTab[$urandom_range(0, 3)];
      wr = 1'($urandom_range(0, 1));
      xfer(wr, $urandom_range(0, 1) == 1 || !wr, a, randBlock(), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
